// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package program_loader_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE, S_ERROR} state_t;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/program_loader_word_packer.sv
// Packs a byte stream big-endian into 32-bit words; flags the byte that completes a word.
module word_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_complete
);
    logic [23:0] shift;
    logic [1:0]  cnt;

    // The completing byte is combined combinationally so the word is ready on the accepting edge.
    assign word          = {shift, byte_in};
    assign word_complete = byte_en && (cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift <= '0;
            cnt   <= '0;
        end else if (clear) begin
            shift <= '0;
            cnt   <= '0;
        end else if (byte_en) begin
            shift <= {shift[15:0], byte_in};
            cnt   <= cnt + 2'd1;
        end
    end
endmodule

// File: rtl/program_loader.sv
// Streams an image into memory word by word, verifies the XOR checksum and releases the CPU.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);
    localparam int WC_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t          state;
    logic [WC_W-1:0] word_cnt;
    logic [7:0]      checksum;
    logic [31:0]     packed_word;
    logic            word_complete;
    logic            accept;
    logic            data_accept;
    logic            start_ok;

    assign accept      = in_valid && in_ready;
    assign data_accept = accept && (state == S_LOAD);
    assign start_ok    = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);

    word_packer u_packer (
        .clk           (clk),
        .reset         (reset),
        .clear         (start_ok),
        .byte_en       (data_accept),
        .byte_in       (in_data),
        .word          (packed_word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            word_cnt <= '0;
            checksum <= '0;
        end else begin
            wr_en <= 1'b0;
            if (word_complete) begin
                wr_en   <= 1'b1;
                wr_addr <= ADDR_W'(word_cnt) << 2;
                wr_data <= packed_word;
            end
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state    <= S_LOAD;
                        in_ready <= 1'b1;
                        word_cnt <= '0;
                        checksum <= '0;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (data_accept) begin
                        checksum <= checksum ^ in_data;
                        if (word_complete) begin
                            if (word_cnt == WC_W'(DEPTH - 1))
                                state <= S_CHECK;
                            else
                                word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == checksum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench: loads push expected memory writes, a negedge monitor pops and compares them.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    // Image A: word k = 0x10000000+k, XOR of all bytes = 0x00.
    // Image B: same but word 31 = 0xDEADBEEF, XOR of all bytes = 0x2D.
    localparam logic [7:0] CSUM_A = 8'h00;
    localparam logic [7:0] CSUM_B = 8'h2D;

    program_loader #(.DEPTH(32), .ADDR_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (!reset && wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual=%h:%h required=none", wr_addr, wr_data);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    errors++;
                    $display("FAIL write actual=%h:%h required=%h:%h",
                             wr_addr, wr_data, e[63:32], e[31:0]);
                end
            end
        end
    end

    function automatic logic [31:0] word_of(input int k, input bit alt);
        if (alt && k == 31) return 32'hDEADBEEF;
        return 32'h10000000 + 32'(k);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic load_image(input bit alt, input logic [7:0] csum, input logic [7:0] flip,
                              input bit gaps, input bit poke);
        logic [31:0] w;
        pulse_start();
        chk("start_ready", 32'(in_ready), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        chk("start_error", 32'(error), 32'd0);
        chk("start_hold", 32'(cpu_hold), 32'd1);
        for (int k = 0; k < 32; k++) begin
            w = word_of(k, alt);
            exp_q.push_back({32'(k * 4), w});
            for (int b = 0; b < 4; b++) begin
                if (gaps && $urandom_range(0, 1) == 1) begin
                    @(posedge clk); #1;
                end
                send_byte(w[31 - 8 * b -: 8]);
                if (poke && k == 10 && b == 1) pulse_start();
            end
        end
        if (poke) pulse_start();
        send_byte(csum ^ flip);
        chk("end_done", 32'(done), (flip == 8'h00) ? 32'd1 : 32'd0);
        chk("end_error", 32'(error), (flip == 8'h00) ? 32'd0 : 32'd1);
        chk("end_hold", 32'(cpu_hold), (flip == 8'h00) ? 32'd0 : 32'd1);
        chk("end_ready", 32'(in_ready), 32'd0);
        chk("writes_left", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w;
        reset = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_addr", wr_addr, 32'd0);
        chk("rst_data", wr_data, 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        // Idle with valid bytes offered: nothing may be consumed or written.
        in_valid = 1'b1; in_data = 8'hAA;
        repeat (10) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("idle_ready", 32'(in_ready), 32'd0);
        chk("idle_hold", 32'(cpu_hold), 32'd1);

        load_image(1'b0, CSUM_A, 8'h00, 1'b0, 1'b0);   // full rate, good
        load_image(1'b0, CSUM_A, 8'h01, 1'b0, 1'b0);   // bad checksum
        load_image(1'b0, CSUM_A, 8'h00, 1'b0, 1'b0);   // recovery
        load_image(1'b1, CSUM_B, 8'h00, 1'b0, 1'b0);   // alternate image
        load_image(1'b1, CSUM_B, 8'h00, 1'b1, 1'b0);   // random valid gaps
        load_image(1'b0, CSUM_A, 8'h00, 1'b0, 1'b1);   // stray start pulses

        // Reset after two bytes of word 5.
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            w = word_of(k, 1'b0);
            exp_q.push_back({32'(k * 4), w});
            for (int b = 0; b < 4; b++) send_byte(w[31 - 8 * b -: 8]);
        end
        w = word_of(5, 1'b0);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        chk("partial_writes_left", 32'(exp_q.size()), 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_addr", wr_addr, 32'd0);
        chk("mid_rst_data", wr_data, 32'd0);
        chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        load_image(1'b0, CSUM_A, 8'h00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
